// File: rtl/arb8_rr_seg_if.sv
// Request/grant bundle for the 8-way arbiter: requester-side inputs and the
// registered grant, owner index, status flags and seven-segment digit.
interface arb8_rr_seg_if;
  logic       en_i;
  logic [7:0] req_i;
  logic       release_i;
  logic [7:0] gnt_o;
  logic [2:0] gnt_id_o;
  logic       busy_o;
  logic       timeout_o;
  logic [6:0] seg_o;

  modport master (
    output en_i, req_i, release_i,
    input  gnt_o, gnt_id_o, busy_o, timeout_o, seg_o
  );

  modport slave (
    input  en_i, req_i, release_i,
    output gnt_o, gnt_id_o, busy_o, timeout_o, seg_o
  );
endinterface

// File: rtl/arb8_rr_seg.sv
// 8-way arbiter with registered one-hot grant, optional hold timeout, a mandatory
// one-cycle gap between owners, and the owner index on an active-low 7-seg digit.
module arb8_rr_seg #(
  parameter bit          RR       = 1'b1,
  parameter int unsigned MAX_HOLD = 15
) (
  input logic          clk,
  input logic          clrn,
  arb8_rr_seg_if.slave bus
);

  localparam int HW = (MAX_HOLD == 32'd0) ? 1 : $clog2(MAX_HOLD + 32'd1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 32'd0) ? 32'd0 : MAX_HOLD - 32'd1);
  localparam logic [HW-1:0] HOLD_SAT  = {HW{1'b1}};
  localparam logic [6:0]    SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [2:0]    gnt_id_q, gnt_id_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic [6:0]    seg_q, seg_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]    last_id_q, last_id_d;

  logic [2:0]    win_id_s;
  logic          win_vld_s;

  function automatic logic [6:0] seg_digit(input logic [2:0] id);
    logic [6:0] s;
    case (id)
      3'd0:    s = 7'b1000000;
      3'd1:    s = 7'b1111001;
      3'd2:    s = 7'b0100100;
      3'd3:    s = 7'b0110000;
      3'd4:    s = 7'b0011001;
      3'd5:    s = 7'b0010010;
      3'd6:    s = 7'b0000010;
      3'd7:    s = 7'b1111000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Winner selection: rotating scan starting after last_id, or highest index
  always_comb begin
    logic [2:0] idx;
    logic       hit;
    win_id_s  = 3'd0;
    win_vld_s = 1'b0;
    idx       = 3'd0;
    hit       = 1'b0;
    if (RR) begin
      for (int k = 1; k <= 8; k++) begin
        idx       = last_id_q + 3'(k);
        hit       = bus.req_i[idx] & ~win_vld_s;
        win_id_s  = hit ? idx : win_id_s;
        win_vld_s = win_vld_s | hit;
      end
    end else begin
      // Ascending scan: the last set bit seen is the highest index
      for (int i = 0; i < 8; i++) begin
        hit       = bus.req_i[i];
        win_id_s  = hit ? 3'(i) : win_id_s;
        win_vld_s = win_vld_s | hit;
      end
    end
  end

  // Next-state and next-output logic for IDLE / GRANT / GAP
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    seg_d      = seg_q;
    hold_cnt_d = hold_cnt_q;
    last_id_d  = last_id_q;

    case (state_q)
      IDLE: begin
        if (bus.en_i && win_vld_s) begin
          state_d    = GRANT;
          gnt_d      = 8'd1 << win_id_s;
          gnt_id_d   = win_id_s;
          busy_d     = 1'b1;
          seg_d      = seg_digit(win_id_s);
          hold_cnt_d = {HW{1'b0}};
          last_id_d  = win_id_s;
        end else begin
          gnt_d  = 8'd0;
          busy_d = 1'b0;
          seg_d  = SEG_DASH;
        end
      end

      GRANT: begin
        hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + {{(HW-1){1'b0}}, 1'b1};
        // Exit causes are checked in priority order; only the hold limit pulses timeout
        if (!bus.en_i || bus.release_i || !bus.req_i[gnt_id_q]) begin
          state_d = GAP;
          gnt_d   = 8'd0;
          busy_d  = 1'b0;
          seg_d   = SEG_DASH;
        end else if ((MAX_HOLD != 32'd0) && (hold_cnt_q == HOLD_LAST)) begin
          state_d   = GAP;
          gnt_d     = 8'd0;
          busy_d    = 1'b0;
          seg_d     = SEG_DASH;
          timeout_d = 1'b1;
        end else begin
          state_d = GRANT;
        end
      end

      GAP: begin
        state_d    = IDLE;
        gnt_d      = 8'd0;
        busy_d     = 1'b0;
        seg_d      = SEG_DASH;
        hold_cnt_d = {HW{1'b0}};
      end

      default: begin
        state_d    = IDLE;
        gnt_d      = 8'd0;
        busy_d     = 1'b0;
        seg_d      = SEG_DASH;
        hold_cnt_d = {HW{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      gnt_q      <= 8'd0;
      gnt_id_q   <= 3'd0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      seg_q      <= SEG_DASH;
      hold_cnt_q <= {HW{1'b0}};
      last_id_q  <= 3'd7;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      seg_q      <= seg_d;
      hold_cnt_q <= hold_cnt_d;
      last_id_q  <= last_id_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_id_o  = gnt_id_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = timeout_q;
  assign bus.seg_o     = seg_q;

endmodule

// File: tb/tb_arb8_rr_seg.sv
// Bench for arb8_rr_seg: three configurations driven in parallel, checked each
// cycle against an owner/gap/hold-count reference model.
module tb_arb8_rr_seg;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic       en_s;
  logic [7:0] req_s;
  logic       rel_s;

  arb8_rr_seg_if bus0 ();
  arb8_rr_seg_if bus1 ();
  arb8_rr_seg_if bus2 ();

  assign bus0.en_i = en_s;  assign bus0.req_i = req_s;  assign bus0.release_i = rel_s;
  assign bus1.en_i = en_s;  assign bus1.req_i = req_s;  assign bus1.release_i = rel_s;
  assign bus2.en_i = en_s;  assign bus2.req_i = req_s;  assign bus2.release_i = rel_s;

  arb8_rr_seg #(.RR(1'b1), .MAX_HOLD(15)) dut0 (.clk(clk), .clrn(clrn), .bus(bus0.slave));
  arb8_rr_seg #(.RR(1'b0), .MAX_HOLD(15)) dut1 (.clk(clk), .clrn(clrn), .bus(bus1.slave));
  arb8_rr_seg #(.RR(1'b1), .MAX_HOLD(3))  dut2 (.clk(clk), .clrn(clrn), .bus(bus2.slave));

  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference model: who owns the resource, for how long, and whether the gap is pending
  int c_rr [3] = '{1, 0, 1};
  int c_mh [3] = '{15, 15, 3};
  int m_owner [3];
  int m_id [3];
  int m_last [3];
  int m_hold [3];
  bit m_gap [3];
  bit m_to [3];

  logic [6:0] seg_tab [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
  localparam logic [6:0] DASH = 7'b0111111;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input int d, input logic [7:0] r);
    int w;
    w = -1;
    if (c_rr[d] != 0) begin
      for (int k = 8; k >= 1; k--)
        if (r[(m_last[d] + k) % 8]) w = (m_last[d] + k) % 8;
    end else begin
      for (int i = 0; i < 8; i++)
        if (r[i]) w = i;
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = -1; m_id[d] = 0; m_last[d] = 7;
      m_hold[d] = 0;   m_gap[d] = 1'b0; m_to[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    int w;
    for (int d = 0; d < 3; d++) begin
      m_to[d] = 1'b0;
      if (m_owner[d] >= 0) begin
        m_hold[d]++;
        if (!en_s || rel_s || !req_s[m_owner[d]]) begin
          m_owner[d] = -1; m_gap[d] = 1'b1;
        end else if (c_mh[d] != 0 && m_hold[d] == c_mh[d]) begin
          m_owner[d] = -1; m_gap[d] = 1'b1; m_to[d] = 1'b1;
        end
      end else if (m_gap[d]) begin
        m_gap[d] = 1'b0;
      end else if (en_s && req_s != 8'd0) begin
        w = pick(d, req_s);
        m_owner[d] = w; m_id[d] = w; m_last[d] = w; m_hold[d] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] g, eg;
    logic [2:0] id;
    logic       b, t;
    logic [6:0] s, es;
    for (int d = 0; d < 3; d++) begin
      case (d)
        0:       begin g = bus0.gnt_o; id = bus0.gnt_id_o; b = bus0.busy_o; t = bus0.timeout_o; s = bus0.seg_o; end
        1:       begin g = bus1.gnt_o; id = bus1.gnt_id_o; b = bus1.busy_o; t = bus1.timeout_o; s = bus1.seg_o; end
        default: begin g = bus2.gnt_o; id = bus2.gnt_id_o; b = bus2.busy_o; t = bus2.timeout_o; s = bus2.seg_o; end
      endcase
      eg = 8'd0;
      es = DASH;
      if (m_owner[d] >= 0) begin
        eg = 8'd1;
        eg = eg << m_owner[d];
        es = seg_tab[m_owner[d]];
      end
      check_eq($sformatf("d%0d gnt", d), {24'd0, g}, {24'd0, eg});
      check_eq($sformatf("d%0d gnt_id", d), {29'd0, id}, m_id[d]);
      check_eq($sformatf("d%0d busy", d), {31'd0, b}, {31'd0, (m_owner[d] >= 0)});
      check_eq($sformatf("d%0d timeout", d), {31'd0, t}, {31'd0, m_to[d]});
      check_eq($sformatf("d%0d seg", d), {25'd0, s}, {25'd0, es});
    end
  endtask

  // One clock: drive at negedge, advance the model at posedge, sample 1 time unit later
  task automatic cycle(input logic e, input logic [7:0] r, input logic rl);
    en_s = e; req_s = r; rel_s = rl;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2;
    clrn = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  initial begin
    en_s = 1'b0; req_s = 8'd0; rel_s = 1'b0;
    clrn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    clrn = 1'b1;

    // Round-robin prefers 0 first after reset, then 7 after the gap
    cycle(1'b1, 8'h81, 1'b0);
    check_eq("tp1 first gnt", {24'd0, bus0.gnt_o}, 32'h01);
    check_eq("tp1 first seg", {25'd0, bus0.seg_o}, 32'h40);
    check_eq("tp1 fixed gnt", {24'd0, bus1.gnt_o}, 32'h80);
    cycle(1'b1, 8'h81, 1'b1);
    cycle(1'b1, 8'h81, 1'b0);
    cycle(1'b1, 8'h81, 1'b0);
    check_eq("tp1 second gnt", {24'd0, bus0.gnt_o}, 32'h80);
    check_eq("tp1 second seg", {25'd0, bus0.seg_o}, 32'h78);

    // Fixed priority on 0x2C keeps returning to 5; release pulsed periodically
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'h2C, (i % 4) == 1);
    check_eq("tp2 fixed id", {29'd0, bus1.gnt_id_o}, 32'd5);

    // All requesting, release held: one-cycle grants rotating through every index
    for (int i = 0; i < 30; i++) cycle(1'b1, 8'hFF, 1'b1);

    // Single requester held: timeout after MAX_HOLD cycles, then regrant
    for (int i = 0; i < 45; i++) cycle(1'b1, 8'h08, 1'b0);

    // Disable while granted, then disabled with everyone requesting
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'hFF, 1'b0);
    check_eq("tp5 no grant", {24'd0, bus0.gnt_o}, 32'h00);

    // Asynchronous reset mid-grant, then round-robin restarts from index 0
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 1'b0);
    async_reset();
    check_eq("tp6 seg dash", {25'd0, bus0.seg_o}, 32'h3F);
    cycle(1'b1, 8'h90, 1'b0);
    check_eq("tp6 rr id", {29'd0, bus0.gnt_id_o}, 32'd4);
    check_eq("tp6 fixed id", {29'd0, bus1.gnt_id_o}, 32'd7);

    // Randomized traffic with occasional withdrawal, disable and reset
    for (int i = 0; i < 3000; i++) begin
      logic       e, rl;
      logic [7:0] r;
      e  = ($urandom_range(0, 15) != 0);
      r  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom & $urandom & $urandom);
      rl = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0) r = r | req_s;
      cycle(e, r, rl);
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
